mux_scan_n: RTL and testbench

Parametrised, registered N-channel W-bit multiplexer; next generation of the lab 2:1 mux (w0, w1, s → f). It adds a registered output with an enable, an output-valid flag and a channel-index echo. An optional auto-scan mode steps through all channels, holding each for a programmable dwell time. It sits between multi-channel data sources and a single downstream consumer (display or serial stage).

---
 rtl/mux_scan_n_pkg.sv | 22 ++
 rtl/mux_scan_ctr.sv | 69 ++++++
 rtl/mux_scan_n.sv | 137 +++++++++++++
 tb/tb_mux_scan_n.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_n_pkg.sv
// mux_scan_n_pkg
// Shared definitions for the registered N-channel multiplexer and its
// scan counter.
//   state_t          : controller states, ST_MANUAL = 1'b0, ST_SCAN = 1'b1
//   N_DEF/W_DEF/...  : default parameter values used by both modules
//   cnt_width()      : width of a counter that counts 0..n-1, never below 1
package mux_scan_n_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    localparam int N_DEF     = 4;
    localparam int W_DEF     = 8;
    localparam int DWELL_DEF = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr
// Dwell / channel counter for the auto-scan mode of mux_scan_n.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   clr      in   restart the scan at channel 0, dwell 0 (this cycle's value)
//   en       in   advance by one enabled scan beat
//   chan_cnt out  channel to present on this beat (already reflects clr)
//   wrap     out  registered pulse on the last beat of channel N-1
module mux_scan_ctr
    import mux_scan_n_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [$clog2(N)-1:0] chan_cnt,
    output logic                 wrap
);

    localparam int SW = $clog2(N);
    localparam int DW = cnt_width(DWELL);

    logic [SW-1:0] chan_reg, chan_next, chan_base;
    logic [DW-1:0] dwell_reg, dwell_next, dwell_base;
    logic          wrap_reg, wrap_next;

    // clr takes effect on the same cycle: the beat presented on the
    // entry edge is channel 0, and counting continues from there.
    always_comb begin
        chan_base  = clr ? '0 : chan_reg;
        dwell_base = clr ? '0 : dwell_reg;
        chan_next  = chan_base;
        dwell_next = dwell_base;
        wrap_next  = 1'b0;
        if (en) begin
            if (dwell_base == DW'(DWELL - 1)) begin
                dwell_next = '0;
                if (chan_base == SW'(N - 1)) begin
                    chan_next = '0;
                    wrap_next = 1'b1;
                end else begin
                    chan_next = chan_base + SW'(1);
                end
            end else begin
                dwell_next = dwell_base + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chan_reg  <= '0;
            dwell_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            chan_reg  <= chan_next;
            dwell_reg <= dwell_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign chan_cnt = chan_base;
    assign wrap     = wrap_reg;

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n
// Registered N-channel, W-bit multiplexer with enable, valid flag, channel
// echo and an optional auto-scan mode (macro MUX_SCAN_N_SCAN_EN). Without
// the macro the block is manual-only, mode is ignored and wrap is 0.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   en     in   update / advance enable
//   mode   in   0 = manual select, 1 = auto-scan
//   sel    in   manual channel select
//   din    in   packed channels, channel k at din[k*W +: W]
//   dout   out  registered selected data
//   ch     out  index of the channel on dout
//   valid  out  dout/ch updated from a legal channel this cycle
//   wrap   out  pulse on the last beat of channel N-1 in scan mode
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    input  logic [N*W-1:0]       din,
    output logic [W-1:0]         dout,
    output logic [$clog2(N)-1:0] ch,
    output logic                 valid,
    output logic                 wrap
);

    localparam int SW = $clog2(N);

    logic [W-1:0]  chan_data [N];
    logic          sel_legal;
    logic          scan_active;
    logic [SW-1:0] scan_ch;

    logic [W-1:0]  dout_reg, dout_next;
    logic [SW-1:0] ch_reg, ch_next;
    logic          valid_reg, valid_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign chan_data[gi] = din[gi*W +: W];
        end
    endgenerate

    // Only matters for non-power-of-two N, where sel can name a missing channel.
    assign sel_legal = (32'(sel) < N);

`ifdef MUX_SCAN_N_SCAN_EN
    state_t state_reg, state_next;
    logic   ctr_clr, ctr_en, wrap_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_MANUAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_MANUAL;
        if (mode) begin
            state_next = ST_SCAN;
        end
    end

    // Mode changes act on the same edge, so the data path follows the
    // next state rather than the registered one.
    assign scan_active = (state_next == ST_SCAN);
    assign ctr_clr     = (state_reg == ST_MANUAL) && scan_active;
    assign ctr_en      = en && scan_active;

    mux_scan_ctr #(
        .N     (N),
        .DWELL (DWELL)
    ) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .chan_cnt (scan_ch),
        .wrap     (wrap_int)
    );

    assign wrap = wrap_int;
`else
    logic unused_cfg;

    assign scan_active = 1'b0;
    assign scan_ch     = '0;
    assign wrap        = 1'b0;
    assign unused_cfg  = mode ^ (DWELL > 0);
`endif

    always_comb begin
        dout_next  = dout_reg;
        ch_next    = ch_reg;
        valid_next = 1'b0;
        if (en) begin
            if (scan_active) begin
                dout_next  = chan_data[scan_ch];
                ch_next    = scan_ch;
                valid_next = 1'b1;
            end else if (sel_legal) begin
                dout_next  = chan_data[sel];
                ch_next    = sel;
                valid_next = 1'b1;
            end else begin
                dout_next  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
        end else begin
            dout_reg  <= dout_next;
            ch_reg    <= ch_next;
            valid_reg <= valid_next;
        end
    end

    assign dout  = dout_reg;
    assign ch    = ch_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n
// Self-checking bench for mux_scan_n (N=4, W=8, DWELL=2). Directed test-plan
// scenarios followed by randomized stimulus, all checked against a beat-count
// reference model. Works with or without MUX_SCAN_N_SCAN_EN defined.
module tb_mux_scan_n;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DWELL = 2;
    localparam int SW    = 2;
    localparam logic [N*W-1:0] DIN_TP = 32'h44332211;

    logic          clk = 1'b0;
    logic          rst_n, en, mode;
    logic [SW-1:0] sel;
    logic [N*W-1:0] din;
    logic [W-1:0]  dout;
    logic [SW-1:0] ch;
    logic          valid, wrap;

    mux_scan_n #(.N(N), .W(W), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .din   (din),
        .dout  (dout),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: scan position is a count of enabled scan beats since
    // scan entry; channel and wrap follow from plain division.
    bit         m_scan  = 1'b0;
    int         m_beat  = 0;
    logic [7:0] m_dout  = '0;
    int         m_ch    = 0;
    bit         m_valid = 1'b0;
    bit         m_wrap  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic m,
                              input logic [SW-1:0] s, input logic [N*W-1:0] d);
        bit scan_next;
        int c;
        if (!r) begin
            m_scan = 0; m_beat = 0; m_dout = '0; m_ch = 0; m_valid = 0; m_wrap = 0;
        end else begin
`ifdef MUX_SCAN_N_SCAN_EN
            scan_next = m;
`else
            scan_next = 1'b0;
`endif
            if (scan_next && !m_scan) m_beat = 0;
            m_scan  = scan_next;
            m_valid = 0;
            m_wrap  = 0;
            if (e) begin
                if (m_scan) begin
                    c       = (m_beat / DWELL) % N;
                    m_dout  = d[c*W +: W];
                    m_ch    = c;
                    m_valid = 1;
                    m_wrap  = (m_beat % (N*DWELL)) == (N*DWELL - 1);
                    m_beat++;
                end else if (int'(s) < N) begin
                    m_dout  = d[int'(s)*W +: W];
                    m_ch    = int'(s);
                    m_valid = 1;
                end else begin
                    m_dout  = '0;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic m,
                        input logic [SW-1:0] s, input logic [N*W-1:0] d);
        rst_n = r; en = e; mode = m; sel = s; din = d;
        @(posedge clk);
        model_edge(r, e, m, s, d);
        #1;
        chk({tag, ".dout"},  32'(dout),  32'(m_dout));
        chk({tag, ".ch"},    32'(ch),    32'(m_ch));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
        $display("[TB] %-10s rst_n=%0b en=%0b mode=%0b sel=%0d -> dout=%02h ch=%0d valid=%0b wrap=%0b",
                 tag, r, e, m, s, dout, ch, valid, wrap);
    endtask

    logic [7:0] scan_seq [10];

    initial begin
        scan_seq = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11, 8'h11};
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; din = DIN_TP;

        // Reset with en=1, mode=1: outputs stay zero.
        for (int i = 0; i < 2; i++) begin
            step("reset", 1'b0, 1'b1, 1'b1, 2'd0, DIN_TP);
            chk("reset.zero", {dout, 6'd0, ch, valid, wrap}, 32'd0);
        end

        // Manual sweep.
        for (int i = 0; i < 4; i++) begin
            step("manual", 1'b1, 1'b1, 1'b0, SW'(i), DIN_TP);
            chk("manual.lit", 32'(dout), 32'(8'h11 * (i + 1)));
        end

        // Enable hold.
        step("hold_ld", 1'b1, 1'b1, 1'b0, 2'd2, DIN_TP);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 1'b0, 1'b0, 2'd3, DIN_TP);
            chk("hold.lit", {dout, ch, valid}, {8'h33, 2'd2, 1'b0});
        end

        // Scan for 10 beats (manual-only build: sel=3 gives 44 every cycle).
        for (int i = 0; i < 10; i++) begin
            step("scan", 1'b1, 1'b1, 1'b1, 2'd3, DIN_TP);
`ifdef MUX_SCAN_N_SCAN_EN
            chk("scan.lit", 32'(dout), 32'(scan_seq[i]));
            chk("scan.wrap", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
`else
            chk("scan.lit", {dout, wrap}, {8'h44, 1'b0});
`endif
        end

        // Freeze after first 22 beat, then reset during 33.
        step("to_man", 1'b1, 1'b1, 1'b0, 2'd0, DIN_TP);
        for (int i = 0; i < 3; i++) step("frz_run", 1'b1, 1'b1, 1'b1, 2'd1, DIN_TP);
        step("frz_off", 1'b1, 1'b0, 1'b1, 2'd1, DIN_TP);
        step("frz_on", 1'b1, 1'b1, 1'b1, 2'd1, DIN_TP);
`ifdef MUX_SCAN_N_SCAN_EN
        chk("frz.lit", 32'(dout), 32'h22);
`endif
        step("pre_rst", 1'b1, 1'b1, 1'b1, 2'd1, DIN_TP);
        step("mid_rst", 1'b0, 1'b1, 1'b1, 2'd1, DIN_TP);
        step("post_rst", 1'b1, 1'b1, 1'b1, 2'd1, DIN_TP);
`ifdef MUX_SCAN_N_SCAN_EN
        chk("post_rst.lit", {dout, ch}, {8'h11, 2'd0});
`endif

        // Randomized stimulus.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 7),
                 SW'($urandom_range(0, N - 1)),
                 N*W'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
